// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
//  Module      : muldiv_sequencer_if
//  Description : Execute/Decode-side bundle for the multi-cycle mult/div unit.
//                master = pipeline side, slave = sequencer side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic             divE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hlreadD;
  logic             muldivD;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             hlwrite;
  logic             divzero;
  logic             busy;
  logic             stallhl;

  modport master (
    output startE, divE, signedE, srcaE, srcbE, hlreadD, muldivD, cancel,
    input  hi, lo, hlwrite, divzero, busy, stallhl
  );

  modport slave (
    input  startE, divE, signedE, srcaE, srcbE, hlreadD, muldivD, cancel,
    output hi, lo, hlwrite, divzero, busy, stallhl
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Radix-2 shift-add multiplier / restoring divider feeding the
//                HI/LO registers. Fixed WIDTH+2 cycle latency, sign handled by
//                magnitude arithmetic plus a final fixup cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,    // asynchronous, active-low
  muldiv_sequencer_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   r_op;       // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   r_orig_a;   // raw dividend, returned in HI on divide-by-zero
  logic               r_div;
  logic               r_bzero;
  logic               r_rsign;
  logic               r_remsign;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_hlwrite;
  logic               r_divzero;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_neg_acc;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand magnitudes; unsigned ops pass the raw bits through
  assign w_abs_a = (bus.signedE && bus.srcaE[WIDTH-1]) ? (~bus.srcaE + 1'b1) : bus.srcaE;
  assign w_abs_b = (bus.signedE && bus.srcbE[WIDTH-1]) ? (~bus.srcbE + 1'b1) : bus.srcbE;

  // One shift-add step: add into the upper half when the multiplier LSB is set, then shift right
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_op};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // One restoring-divide step. Since rem < divisor before the shift, the shifted value is below
  // 2*divisor, so the borrow bit of the subtraction alone decides rem >= divisor.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_op};
  assign w_ge       = ~w_sub[WIDTH];
  assign w_div_next = {(w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_neg_acc  = ~r_acc + 1'b1;

  // Sign restoration and divide-by-zero override applied during FIXUP
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_div) begin
      if (r_bzero) begin
        w_fix_hi = r_orig_a;
        w_fix_lo = '1;
      end else begin
        if (r_rsign)   w_fix_lo = ~r_acc[WIDTH-1:0] + 1'b1;
        if (r_remsign) w_fix_hi = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
      end
    end else if (r_rsign) begin
      w_fix_hi = w_neg_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = w_neg_acc[WIDTH-1:0];
    end
  end

  // Sequencer FSM: operand capture, iteration, fixup and the registered HI/LO write pulse.
  // A startE arriving while busy is simply not looked at outside IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_op      <= '0;
      r_orig_a  <= '0;
      r_div     <= 1'b0;
      r_bzero   <= 1'b0;
      r_rsign   <= 1'b0;
      r_remsign <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hlwrite <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_hlwrite <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.startE) begin
            r_op      <= bus.divE ? w_abs_b : w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, (bus.divE ? w_abs_a : w_abs_b)};
            r_orig_a  <= bus.srcaE;
            r_div     <= bus.divE;
            r_bzero   <= (bus.srcbE == '0);
            r_rsign   <= (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]) & bus.signedE;
            r_remsign <= bus.srcaE[WIDTH-1] & bus.signedE;
            r_cnt     <= '0;
            r_state   <= bus.divE ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          if (bus.cancel) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_hi      <= w_fix_hi;
            r_lo      <= w_fix_lo;
            r_hlwrite <= 1'b1;
            r_divzero <= r_div & r_bzero;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.hlwrite = r_hlwrite;
  assign bus.divzero = r_divzero;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.stallhl = bus.busy & (bus.hlreadD | bus.muldivD);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer: directed vector
//                table, hand-written stall/cancel/reset sequences and random
//                operations against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          div;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          edz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input bit div, input bit sgn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] eh, input logic [31:0] el, input bit edz);
    vec_t v;
    v.name = name; v.div = div; v.sgn = sgn; v.a = a; v.b = b;
    v.eh = eh; v.el = el; v.edz = edz;
    return v;
  endfunction

  // Reference: what MULT/MULTU/DIV/DIVU leave in HI/LO, from 64-bit integer arithmetic
  function automatic void model(input bit div, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] eh,
                                output logic [31:0] el, output bit edz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    edz = 1'b0;
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!div) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh  = a;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.startE  = 1'b0;
    bus.divE    = 1'b0;
    bus.signedE = 1'b0;
    bus.srcaE   = '0;
    bus.srcbE   = '0;
    bus.hlreadD = 1'b0;
    bus.muldivD = 1'b0;
    bus.cancel  = 1'b0;
  endtask

  // Issue one operation, wait (bounded) for hlwrite, check latency, result and pulse width
  task automatic run_check(input string name, input bit div, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input bit edz,
                           input bit with_cancel);
    int n;
    bit got;
    @(negedge clk);
    bus.startE  = 1'b1;
    bus.divE    = div;
    bus.signedE = sgn;
    bus.srcaE   = a;
    bus.srcbE   = b;
    bus.cancel  = with_cancel;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.startE = 1'b0;
        bus.cancel = 1'b0;
      end
      if (bus.hlwrite) got = 1'b1;
      else @(posedge clk);
    end
    check({name, " latency"}, 64'(n), 64'(LAT));
    check({name, " hi"}, {32'b0, bus.hi}, {32'b0, eh});
    check({name, " lo"}, {32'b0, bus.lo}, {32'b0, el});
    check({name, " divzero"}, {63'b0, bus.divzero}, {63'b0, edz});
    @(posedge clk);
    @(negedge clk);
    check({name, " pulse end"}, {61'b0, bus.hlwrite, bus.divzero, bus.busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el;
    bit          edz, saw;
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    check("reset flags", {60'b0, bus.hlwrite, bus.divzero, bus.busy, bus.stallhl}, 64'd0);

    // Directed vectors with hand-derived results
    tbl.push_back(mk("multu_max",  0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0));
    tbl.push_back(mk("mult_m3x7",  0, 1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0));
    tbl.push_back(mk("mult_minsq", 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0));
    tbl.push_back(mk("mult_maxxm1",0, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0));
    tbl.push_back(mk("multu_zero", 0, 0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0));
    tbl.push_back(mk("div_m7d2",   1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk("div_7dm2",   1, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk("divu_100d7", 1, 0, 32'd100,       32'd7,         32'd2,         32'd14,        0));
    tbl.push_back(mk("div_mindm1", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0));
    tbl.push_back(mk("divu_bigd",  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0));
    tbl.push_back(mk("div_5d0",    1, 1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk("div_m8d0",   1, 1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk("divu_d0",    1, 0, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1));
    foreach (tbl[i])
      run_check(tbl[i].name, tbl[i].div, tbl[i].sgn, tbl[i].a, tbl[i].b,
                tbl[i].eh, tbl[i].el, tbl[i].edz, 1'b0);

    // Stall while busy (HI/LO read, then a second mult/div in Decode), ignored startE mid-op
    @(negedge clk);
    bus.startE = 1'b1; bus.divE = 1'b0; bus.signedE = 1'b1;
    bus.srcaE = 32'hFFFF_FFFD; bus.srcbE = 32'd7; bus.hlreadD = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.startE = 1'b0;
      if (n == 5) begin
        bus.startE = 1'b1; bus.divE = 1'b1; bus.srcaE = 32'd5; bus.srcbE = 32'd0;
      end
      if (n == 6) bus.startE = 1'b0;
      if (n == 20) begin bus.hlreadD = 1'b0; bus.muldivD = 1'b1; end
      check($sformatf("stallhl cyc %0d", n), {63'b0, bus.stallhl}, {63'b0, (n <= LAT)});
      if (n == LAT) begin
        check("stall op hlwrite", {63'b0, bus.hlwrite}, 64'd1);
        check("stall op result", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("stall op divzero", {63'b0, bus.divzero}, 64'd0);
      end
    end
    clear_inputs();

    // Cancel at iteration 10: no write, previous HI/LO retained
    run_check("pre_cancel", 0, 0, 32'd3, 32'd5, 32'd0, 32'd15, 0, 1'b0);
    @(negedge clk);
    bus.startE = 1'b1; bus.divE = 1'b1; bus.signedE = 1'b0;
    bus.srcaE = 32'd100; bus.srcbE = 32'd7;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.startE = 1'b0;
      if (n == 10) bus.cancel = 1'b1;
    end
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", {63'b0, bus.busy}, 64'd0);
    saw = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.hlwrite) saw = 1'b1;
    end
    check("cancel no hlwrite", {63'b0, saw}, 64'd0);
    check("cancel hi/lo kept", {bus.hi, bus.lo}, {32'd0, 32'd15});

    // Start together with cancel in IDLE: the start wins
    run_check("start_over_cancel", 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.startE = 1'b1; bus.divE = 1'b1; bus.signedE = 1'b1;
    bus.srcaE = 32'hFFFF_FFF9; bus.srcbE = 32'd2; bus.hlreadD = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) bus.startE = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("midreset hi/lo", {bus.hi, bus.lo}, 64'd0);
    check("midreset flags", {60'b0, bus.hlwrite, bus.divzero, bus.busy, bus.stallhl}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit          div, sgn;
      div = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = pick();
      b   = pick();
      model(div, sgn, a, b, eh, el, edz);
      run_check($sformatf("rnd%0d %s%s %h,%h", i, div ? "div" : "mul", sgn ? "" : "u", a, b),
                div, sgn, a, b, eh, el, edz, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
